// File: rtl/sd_tx_fifo_fill_ctrl.sv
// Write-side sequencer for the SD TX FIFO: fetches one block word-by-word from a host
// read port (req/ack) and pushes each word into the FIFO, with backpressure, timeout and abort.
module sd_tx_fifo_fill_ctrl #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned BLKLEN_W = 12,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                wclk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [BLKLEN_W-1:0] blk_words,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [BLKLEN_W-1:0] words_left,
  output logic                m_req,
  output logic [ADDR_W-1:0]   m_addr,
  input  logic                m_ack,
  input  logic [31:0]         m_dat,
  input  logic                fifo_full,
  output logic                fifo_wr,
  output logic [31:0]         fifo_d
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StWaitSpace,
    StReq,
    StDone,
    StErr
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BLKLEN_W-1:0] left_q, left_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic                err_q, err_d;
  logic                wr_q, wr_d;
  logic [31:0]         fifo_d_q, fifo_d_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                req_q, req_d;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    left_d   = left_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    wr_d     = 1'b0;
    fifo_d_d = fifo_d_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          err_d   = 1'b0;
          addr_d  = base_addr;
          left_d  = blk_words;
          state_d = (blk_words == '0) ? StDone : StWaitSpace;
        end
      end
      StWaitSpace: begin
        if (!fifo_full) begin
          state_d = StReq;
          tmo_d   = '0;
        end
      end
      StReq: begin
        if (m_ack) begin
          wr_d     = 1'b1;
          fifo_d_d = m_dat;
          addr_d   = addr_q + ADDR_W'(4);
          left_d   = left_q - BLKLEN_W'(1);
          state_d  = (left_q == BLKLEN_W'(1)) ? StDone : StWaitSpace;
        end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
          state_d = StErr;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Abort beats any concurrent ack or timeout: drop the word, raise nothing.
    if (abort && (state_q != StIdle)) begin
      state_d  = StIdle;
      addr_d   = addr_q;
      left_d   = left_q;
      tmo_d    = tmo_q;
      err_d    = err_q;
      wr_d     = 1'b0;
      fifo_d_d = fifo_d_q;
    end

    busy_d = (state_d == StWaitSpace) || (state_d == StReq);
    done_d = (state_d == StDone);
    req_d  = (state_d == StReq);
  end

  always_ff @(posedge wclk) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      left_q   <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
      wr_q     <= 1'b0;
      fifo_d_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      left_q   <= left_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      wr_q     <= wr_d;
      fifo_d_q <= fifo_d_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      req_q    <= req_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign words_left = left_q;
  assign m_req      = req_q;
  assign m_addr     = addr_q;
  assign fifo_wr    = wr_q;
  assign fifo_d     = fifo_d_q;

endmodule
